hpdcache_mem_inval_queue: RTL

- Upstream feeder for the CMO handler. Accepts invalidation requests from the memory side (by cache-line number), buffers them in a FIFO and issues them one at a time to the CMO handler as invalidate-by-nline operations, with the memory-invalidation qualifier asserted.
- Detects completion when the CMO handler returns to idle, then returns a tagged acknowledgement to the memory side.
- Sits between the memory-interface invalidation port and the CMO handler request port. The top level muxes its request with core-side CMO requests.

---
 rtl/hpdcache_mem_inval_queue_pkg.sv | 15 +
 rtl/hpdcache_mem_inval_queue_if.sv | 36 +++
 rtl/hpdcache_mem_inval_queue_fifo.sv | 49 ++++
 rtl/hpdcache_mem_inval_queue.sv | 87 ++++++++
 4 files changed

// File: rtl/hpdcache_mem_inval_queue_pkg.sv
// Shared types for the memory-side invalidation queue: cache-line number,
// transaction ID and the queue FSM state encoding.
package hpdcache_mem_inval_queue_pkg;
  localparam int unsigned HPDCACHE_NLINE_WIDTH       = 26;
  localparam int unsigned HPDCACHE_MEM_INVAL_ID_WIDTH = 4;

  typedef logic [HPDCACHE_NLINE_WIDTH-1:0]        hpdcache_nline_t;
  typedef logic [HPDCACHE_MEM_INVAL_ID_WIDTH-1:0] hpdcache_mem_inval_id_t;

  typedef enum logic [1:0] {
    QI_IDLE,
    QI_WAIT,
    QI_ACK
  } hpdcache_mem_inval_qstate_t;
endpackage

// File: rtl/hpdcache_mem_inval_queue_if.sv
// Bundle of the memory-side invalidation port, the CMO handler request port
// and the acknowledgement return path. slave = queue side, master = driver.
interface hpdcache_mem_inval_queue_if
  import hpdcache_mem_inval_queue_pkg::*;
#(
  parameter int unsigned ID_WIDTH = HPDCACHE_MEM_INVAL_ID_WIDTH
);
  logic                mem_inval_valid_i;
  logic                mem_inval_ready_o;
  hpdcache_nline_t     mem_inval_nline_i;
  logic [ID_WIDTH-1:0] mem_inval_id_i;
  logic                cmo_req_valid_o;
  logic                cmo_req_ready_i;
  hpdcache_nline_t     cmo_req_nline_o;
  logic                cmo_req_mem_inval_o;
  logic                mem_inval_ack_valid_o;
  logic                mem_inval_ack_ready_i;
  logic [ID_WIDTH-1:0] mem_inval_ack_id_o;
  logic                pending_o;

  modport slave (
    input  mem_inval_valid_i, mem_inval_nline_i, mem_inval_id_i,
    input  cmo_req_ready_i, mem_inval_ack_ready_i,
    output mem_inval_ready_o, cmo_req_valid_o, cmo_req_nline_o,
    output cmo_req_mem_inval_o, mem_inval_ack_valid_o, mem_inval_ack_id_o,
    output pending_o
  );

  modport master (
    output mem_inval_valid_i, mem_inval_nline_i, mem_inval_id_i,
    output cmo_req_ready_i, mem_inval_ack_ready_i,
    input  mem_inval_ready_o, cmo_req_valid_o, cmo_req_nline_o,
    input  cmo_req_mem_inval_o, mem_inval_ack_valid_o, mem_inval_ack_id_o,
    input  pending_o
  );
endinterface

// File: rtl/hpdcache_mem_inval_queue_fifo.sv
// Small power-of-two FIFO holding pending invalidations; full/empty come
// from the registered occupancy counter only.
module hpdcache_mem_inval_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = logic
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q;
  entry_t           mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // A pop never frees space for a push in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end
endmodule

// File: rtl/hpdcache_mem_inval_queue.sv
// Buffers memory-side invalidations and issues them one at a time to the CMO
// handler, acknowledging each by ID once the handler returns to idle.
module hpdcache_mem_inval_queue
  import hpdcache_mem_inval_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = HPDCACHE_MEM_INVAL_ID_WIDTH
) (
  input logic                         clk_i,
  input logic                         rst_ni,
  hpdcache_mem_inval_queue_if.slave   inval_if
);
  typedef logic [ID_WIDTH-1:0] mem_inval_id_t;
  typedef struct packed {
    hpdcache_nline_t nline;
    mem_inval_id_t   id;
  } entry_t;

  hpdcache_mem_inval_qstate_t state_q, state_d;
  entry_t head, in_entry, cur_q;
  logic   full, empty, pop;
  logic   req_valid, req_mem_inval, ack_valid;
  hpdcache_nline_t req_nline;

  assign in_entry = '{nline: inval_if.mem_inval_nline_i, id: inval_if.mem_inval_id_i};

  hpdcache_mem_inval_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inval_if.mem_inval_valid_i),
    .data_i  (in_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= QI_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (pop) cur_q <= head;
  end

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    req_valid     = 1'b0;
    req_mem_inval = 1'b0;
    req_nline     = cur_q.nline;
    ack_valid     = 1'b0;
    unique case (state_q)
      QI_IDLE: begin
        req_valid     = !empty;
        req_mem_inval = !empty;
        req_nline     = head.nline;
        if (!empty && inval_if.cmo_req_ready_i) begin
          pop     = 1'b1;
          state_d = QI_WAIT;
        end
      end
      // Ready is only sampled from the cycle after the handshake on.
      QI_WAIT: begin
        req_mem_inval = 1'b1;
        if (inval_if.cmo_req_ready_i) state_d = QI_ACK;
      end
      QI_ACK: begin
        ack_valid = 1'b1;
        if (inval_if.mem_inval_ack_ready_i) state_d = QI_IDLE;
      end
      default: state_d = QI_IDLE;
    endcase
  end

  assign inval_if.mem_inval_ready_o     = !full;
  assign inval_if.cmo_req_valid_o       = req_valid;
  assign inval_if.cmo_req_nline_o       = req_nline;
  assign inval_if.cmo_req_mem_inval_o   = req_mem_inval;
  assign inval_if.mem_inval_ack_valid_o = ack_valid;
  assign inval_if.mem_inval_ack_id_o    = cur_q.id;
  assign inval_if.pending_o             = !empty || (state_q != QI_IDLE);
endmodule
